df_mid_lsdc_agepick14: RTL and testbench

DF_MID_LSDC_AGEPICK14 -- requirements
Module: df_mid_lsdc_agepick14

---
 rtl/df_mid_lsdc_pkg.sv | 25 ++
 rtl/df_mid_lsdc_matrixcvt14.sv | 23 ++
 rtl/df_mid_lsdc_agepick14.sv | 178 +++++++++++++++++
 tb/tb_df_mid_lsdc_agepick14.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/df_mid_lsdc_pkg.sv
// Shared constants and helpers for the age-matrix picker: parameter limits, triangle indexing, count width.
// Pure package; no logic, no latency, no backpressure.
package df_mid_lsdc_pkg;

  localparam int SIZE_MIN = 2;
  localparam int SIZE_MAX = 64;
  localparam int PORT_MIN = 1;
  localparam int PORT_MAX = 4;

  // Per-entry allocation summary for one cycle; port is the highest allocating port.
  typedef struct packed {
    logic       hit;
    logic [1:0] port;
  } alloc_tag_t;

  // Flat position of pair (i,j), i<j, in row-major upper-triangle storage.
  function automatic int tri_idx(input int i, input int j, input int size);
    return i * size - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  function automatic int cnt_w(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/df_mid_lsdc_matrixcvt14.sv
// Expands triangle age storage into a full SIZE x SIZE older-than matrix (row i older than column j).
// Purely combinational; no backpressure.
module df_mid_lsdc_matrixcvt14 import df_mid_lsdc_pkg::*; #(
  parameter int SIZE = 16
) (
  input  logic [SIZE*(SIZE-1)/2-1:0] age_tri,
  output logic [SIZE*SIZE-1:0]       older
);

  always_comb begin
    older = '0;
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        if (i < j) begin
          older[i*SIZE+j] = age_tri[tri_idx(i, j, SIZE)];
        end else if (i > j) begin
          older[i*SIZE+j] = ~age_tri[tri_idx(j, i, SIZE)];
        end
      end
    end
  end

endmodule

// File: rtl/df_mid_lsdc_agepick14.sv
// Age-ordered entry tracker with per-port oldest pick; state updates one edge after alloc/dealloc, picks combinational.
// Allocation is never stalled. Optional protocol checker (ErrChk) under DF_MID_LSDC_AGEPICK14_CHK_EN.
module df_mid_lsdc_agepick14 import df_mid_lsdc_pkg::*; #(
  parameter int SIZE  = 16,
  parameter int ALLOC = 2,
  parameter int PICK  = 2
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [ALLOC-1:0]           AllocVal,
  input  logic [ALLOC*SIZE-1:0]      AllocIdx,
  input  logic [SIZE-1:0]            Dealloc,
  input  logic [PICK*SIZE-1:0]       Pickable,
  output logic [SIZE-1:0]            Valid,
  output logic [PICK*SIZE-1:0]       Oldest,
  output logic [SIZE-1:0]            OldestM1,
  output logic [$clog2(SIZE+1)-1:0]  Count,
  output logic                       Full,
  output logic                       Empty
`ifdef DF_MID_LSDC_AGEPICK14_CHK_EN
  ,
  output logic                       ErrChk
`endif
);

  localparam int NT = SIZE * (SIZE - 1) / 2;
  localparam int CW = cnt_w(SIZE);

  if (SIZE < SIZE_MIN || SIZE > SIZE_MAX) begin : g_bad_size
    $error("df_mid_lsdc_agepick14: SIZE out of range");
  end
  if (ALLOC < PORT_MIN || ALLOC > PORT_MAX) begin : g_bad_alloc
    $error("df_mid_lsdc_agepick14: ALLOC out of range");
  end
  if (PICK < PORT_MIN || PICK > PORT_MAX) begin : g_bad_pick
    $error("df_mid_lsdc_agepick14: PICK out of range");
  end

  logic [SIZE-1:0]      valid_q;
  logic [SIZE-1:0]      valid_nxt;
  logic [NT-1:0]        age_q;
  logic [NT-1:0]        age_nxt;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_nxt;
  logic                 full_q;
  logic                 empty_q;
  logic [SIZE-1:0]      alloc_vec;
  alloc_tag_t           tag [SIZE];
  logic [SIZE*SIZE-1:0] older;
  logic [PICK*SIZE-1:0] elig;
  logic [6:0]           n_older;

  // Later ports overwrite earlier ones so an entry takes the youngest rank it was given.
  always_comb begin
    for (int k = 0; k < SIZE; k++) begin
      tag[k] = '0;
      for (int p = 0; p < ALLOC; p++) begin
        if (AllocVal[p] && AllocIdx[p*SIZE+k]) begin
          tag[k].hit  = 1'b1;
          tag[k].port = 2'(p);
        end
      end
      alloc_vec[k] = tag[k].hit;
    end
  end

  assign valid_nxt = (valid_q & ~Dealloc) | alloc_vec;

  always_comb begin
    cnt_nxt = '0;
    for (int k = 0; k < SIZE; k++) begin
      cnt_nxt = cnt_nxt + CW'(valid_nxt[k]);
    end
  end

  // Allocated entries move behind everything else; among themselves lower port is older.
  always_comb begin
    age_nxt = age_q;
    for (int i = 0; i < SIZE; i++) begin
      for (int j = i + 1; j < SIZE; j++) begin
        if (alloc_vec[i] && alloc_vec[j]) begin
          age_nxt[tri_idx(i, j, SIZE)] = (tag[i].port <= tag[j].port);
        end else if (alloc_vec[i]) begin
          age_nxt[tri_idx(i, j, SIZE)] = 1'b0;
        end else if (alloc_vec[j]) begin
          age_nxt[tri_idx(i, j, SIZE)] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q <= '0;
      age_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      valid_q <= valid_nxt;
      age_q   <= age_nxt;
      cnt_q   <= cnt_nxt;
      full_q  <= (cnt_nxt == CW'(SIZE));
      empty_q <= (cnt_nxt == '0);
    end
  end

  df_mid_lsdc_matrixcvt14 #(
    .SIZE (SIZE)
  ) u_matrixcvt (
    .age_tri (age_q),
    .older   (older)
  );

  assign elig = {PICK{valid_q}} & Pickable;

  // The stored order is always total, so "zero older" and "one older" are each unique.
  always_comb begin
    Oldest   = '0;
    OldestM1 = '0;
    n_older  = '0;
    for (int p = 0; p < PICK; p++) begin
      for (int i = 0; i < SIZE; i++) begin
        n_older = '0;
        for (int j = 0; j < SIZE; j++) begin
          if (elig[p*SIZE+j] && older[j*SIZE+i]) begin
            n_older = n_older + 7'd1;
          end
        end
        Oldest[p*SIZE+i] = elig[p*SIZE+i] && (n_older == 7'd0);
        if (p == 0) begin
          OldestM1[i] = elig[i] && (n_older == 7'd1);
        end
      end
    end
  end

  assign Valid = valid_q;
  assign Count = cnt_q;
  assign Full  = full_q;
  assign Empty = empty_q;

`ifdef DF_MID_LSDC_AGEPICK14_CHK_EN
  logic            err_q;
  logic            err_det;
  logic [SIZE-1:0] idx_a;
  logic [SIZE-1:0] idx_b;

  always_comb begin
    err_det = |(alloc_vec & valid_q & ~Dealloc);
    idx_a   = '0;
    idx_b   = '0;
    for (int p = 0; p < ALLOC; p++) begin
      idx_a = AllocIdx[p*SIZE +: SIZE];
      if (AllocVal[p] && ((idx_a & (idx_a - 1'b1)) != '0)) begin
        err_det = 1'b1;
      end
      for (int q = p + 1; q < ALLOC; q++) begin
        idx_b = AllocIdx[q*SIZE +: SIZE];
        if (AllocVal[p] && AllocVal[q] && |(idx_a & idx_b)) begin
          err_det = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else if (err_det) begin
      err_q <= 1'b1;
    end
  end

  assign ErrChk = err_q;
`endif

endmodule

// File: tb/tb_df_mid_lsdc_agepick14.sv
// Bench for df_mid_lsdc_agepick14 at SIZE=4, ALLOC=2, PICK=2: directed table, reset corners, random vs age-list model.
// ErrChk checks are active when DF_MID_LSDC_AGEPICK14_CHK_EN is defined.
module tb_df_mid_lsdc_agepick14;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] AllocVal;
  logic [7:0] AllocIdx;
  logic [3:0] Dealloc;
  logic [7:0] Pickable;
  logic [3:0] Valid;
  logic [7:0] Oldest;
  logic [3:0] OldestM1;
  logic [2:0] Count;
  logic       Full;
  logic       Empty;
`ifdef DF_MID_LSDC_AGEPICK14_CHK_EN
  logic       ErrChk;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  df_mid_lsdc_agepick14 #(
    .SIZE  (4),
    .ALLOC (2),
    .PICK  (2)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .AllocVal (AllocVal),
    .AllocIdx (AllocIdx),
    .Dealloc  (Dealloc),
    .Pickable (Pickable),
    .Valid    (Valid),
    .Oldest   (Oldest),
    .OldestM1 (OldestM1),
    .Count    (Count),
    .Full     (Full),
    .Empty    (Empty)
`ifdef DF_MID_LSDC_AGEPICK14_CHK_EN
    ,
    .ErrChk   (ErrChk)
`endif
  );

  typedef struct {
    logic [1:0] av;
    logic [3:0] i0, i1, d, p0, p1;
    logic [3:0] v, o0, o1, m1;
    logic [2:0] c;
    logic       f, e;
  } vec_t;

  vec_t tbl [12];

  // Reference: entries listed oldest first.
  int   mq[$];
  logic merr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] av, input logic [3:0] i0, input logic [3:0] i1,
                       input logic [3:0] d, input logic [3:0] p0, input logic [3:0] p1);
    AllocVal = av;
    AllocIdx = {i1, i0};
    Dealloc  = d;
    Pickable = {p1, p0};
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  function automatic int idx_of(input logic [3:0] oh);
    for (int k = 0; k < 4; k++) if (oh[k]) return k;
    return 0;
  endfunction

  task automatic model_apply(input logic [1:0] av, input logic [3:0] i0, input logic [3:0] i1,
                             input logic [3:0] d);
    int         nq[$];
    logic [3:0] alloc;
    alloc = (av[0] ? i0 : 4'b0) | (av[1] ? i1 : 4'b0);
    foreach (mq[k]) begin
      if (alloc[mq[k]] && !d[mq[k]]) merr = 1'b1;
      if (!d[mq[k]] && !alloc[mq[k]]) nq.push_back(mq[k]);
    end
    if (av[0]) nq.push_back(idx_of(i0));
    if (av[1]) nq.push_back(idx_of(i1));
    mq = nq;
  endtask

  function automatic logic [3:0] m_valid();
    logic [3:0] r;
    r = '0;
    foreach (mq[k]) r[mq[k]] = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] m_nth(input logic [3:0] pm, input int nth);
    logic [3:0] r;
    int         seen;
    r    = '0;
    seen = 0;
    foreach (mq[k]) begin
      if (pm[mq[k]]) begin
        if (seen == nth) begin
          r[mq[k]] = 1'b1;
          return r;
        end
        seen++;
      end
    end
    return r;
  endfunction

  initial begin
    tbl[0]  = '{2'b01, 4'b0100, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 3'd1, 1'b0, 1'b0};
    tbl[1]  = '{2'b01, 4'b0001, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0101, 4'b0100, 4'b0100, 4'b0001, 3'd2, 1'b0, 1'b0};
    tbl[2]  = '{2'b01, 4'b1000, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1101, 4'b0100, 4'b0100, 4'b0001, 3'd3, 1'b0, 1'b0};
    tbl[3]  = '{2'b00, 4'b0000, 4'b0000, 4'b1000, 4'b1111, 4'b1111, 4'b0101, 4'b0100, 4'b0100, 4'b0001, 3'd2, 1'b0, 1'b0};
    tbl[4]  = '{2'b01, 4'b0100, 4'b0000, 4'b0100, 4'b1111, 4'b1111, 4'b0101, 4'b0001, 4'b0001, 4'b0100, 3'd2, 1'b0, 1'b0};
    tbl[5]  = '{2'b10, 4'b0010, 4'b1000, 4'b0000, 4'b1111, 4'b1111, 4'b1101, 4'b0001, 4'b0001, 4'b0100, 3'd3, 1'b0, 1'b0};
    tbl[6]  = '{2'b01, 4'b0010, 4'b0000, 4'b0000, 4'b1111, 4'b1000, 4'b1111, 4'b0001, 4'b1000, 4'b0100, 3'd4, 1'b1, 1'b0};
    tbl[7]  = '{2'b00, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b1};
    tbl[8]  = '{2'b11, 4'b0010, 4'b1000, 4'b0000, 4'b1111, 4'b1111, 4'b1010, 4'b0010, 4'b0010, 4'b1000, 3'd2, 1'b0, 1'b0};
    tbl[9]  = '{2'b00, 4'b0001, 4'b0100, 4'b0100, 4'b1111, 4'b1111, 4'b1010, 4'b0010, 4'b0010, 4'b1000, 3'd2, 1'b0, 1'b0};
    tbl[10] = '{2'b01, 4'b0010, 4'b0000, 4'b0000, 4'b1111, 4'b0101, 4'b1010, 4'b1000, 4'b0000, 4'b0010, 3'd2, 1'b0, 1'b0};
    tbl[11] = '{2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1010, 4'b0000, 4'b1000, 4'b0000, 3'd2, 1'b0, 1'b0};

    Reset = 1'b1;
    drive(2'b00, 4'b0, 4'b0, 4'b0, 4'b1111, 4'b1111);
    #2;
    chk("rst valid", 32'(Valid), 32'h0);
    chk("rst count", 32'(Count), 32'h0);
    chk("rst empty", 32'(Empty), 32'h1);
    chk("rst full", 32'(Full), 32'h0);
    chk("rst oldest", 32'(Oldest), 32'h0);
    chk("rst oldestm1", 32'(OldestM1), 32'h0);
`ifdef DF_MID_LSDC_AGEPICK14_CHK_EN
    chk("rst errchk", 32'(ErrChk), 32'h0);
`endif
    tick;
    Reset = 1'b0;

    for (int k = 0; k < 12; k++) begin
      drive(tbl[k].av, tbl[k].i0, tbl[k].i1, tbl[k].d, tbl[k].p0, tbl[k].p1);
      tick;
      chk($sformatf("vec%0d valid", k), 32'(Valid), 32'(tbl[k].v));
      chk($sformatf("vec%0d oldest", k), 32'(Oldest), 32'({tbl[k].o1, tbl[k].o0}));
      chk($sformatf("vec%0d oldestm1", k), 32'(OldestM1), 32'(tbl[k].m1));
      chk($sformatf("vec%0d count", k), 32'(Count), 32'(tbl[k].c));
      chk($sformatf("vec%0d full", k), 32'(Full), 32'(tbl[k].f));
      chk($sformatf("vec%0d empty", k), 32'(Empty), 32'(tbl[k].e));
    end

    // Reset asserted mid-cycle while both ports allocate.
    drive(2'b11, 4'b0001, 4'b0100, 4'b0000, 4'b1111, 4'b1111);
    tick;
    drive(2'b11, 4'b0010, 4'b1000, 4'b0000, 4'b1111, 4'b1111);
    #2;
    Reset = 1'b1;
    #1;
    chk("midrst valid", 32'(Valid), 32'h0);
    chk("midrst count", 32'(Count), 32'h0);
    chk("midrst empty", 32'(Empty), 32'h1);
    chk("midrst full", 32'(Full), 32'h0);
    chk("midrst oldest", 32'(Oldest), 32'h0);
    tick;
    Reset = 1'b0;
    drive(2'b00, 4'b0, 4'b0, 4'b0, 4'b1111, 4'b1111);
    tick;
    chk("postrst valid", 32'(Valid), 32'h0);
    chk("postrst count", 32'(Count), 32'h0);
    chk("postrst empty", 32'(Empty), 32'h1);
    chk("postrst oldest", 32'(Oldest), 32'h0);
    drive(2'b01, 4'b1000, 4'b0, 4'b0, 4'b1111, 4'b1111);
    tick;
    chk("firstalloc valid", 32'(Valid), 32'h8);
    chk("firstalloc oldest", 32'(Oldest), 32'h88);

`ifdef DF_MID_LSDC_AGEPICK14_CHK_EN
    drive(2'b01, 4'b0010, 4'b0, 4'b0, 4'b1111, 4'b1111);
    tick;
    chk("err clean alloc", 32'(ErrChk), 32'h0);
    drive(2'b01, 4'b0010, 4'b0, 4'b0, 4'b1111, 4'b1111);
    tick;
    chk("err realloc", 32'(ErrChk), 32'h1);
    drive(2'b00, 4'b0, 4'b0, 4'b1111, 4'b1111, 4'b1111);
    tick;
    tick;
    chk("err sticky", 32'(ErrChk), 32'h1);
    Reset = 1'b1;
    #1;
    chk("err cleared", 32'(ErrChk), 32'h0);
    #1;
    Reset = 1'b0;
    tick;
`endif

    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    mq.delete();
    merr = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [1:0] av;
      logic [3:0] i0, i1, d, p0, p1;
      av = 2'($urandom_range(0, 3));
      i0 = 4'b0001 << $urandom_range(0, 3);
      i1 = 4'b0001 << $urandom_range(0, 3);
      if (av == 2'b11 && i0 == i1) av = 2'b01;
      d  = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      p0 = 4'($urandom_range(0, 15) | $urandom_range(0, 15));
      p1 = 4'($urandom_range(0, 15));
      model_apply(av, i0, i1, d);
      drive(av, i0, i1, d, p0, p1);
      tick;
      chk($sformatf("rnd%0d valid", n), 32'(Valid), 32'(m_valid()));
      chk($sformatf("rnd%0d oldest", n), 32'(Oldest), 32'({m_nth(p1, 0), m_nth(p0, 0)}));
      chk($sformatf("rnd%0d oldestm1", n), 32'(OldestM1), 32'(m_nth(p0, 1)));
      chk($sformatf("rnd%0d count", n), 32'(Count), 32'(mq.size()));
      chk($sformatf("rnd%0d full", n), 32'(Full), 32'(mq.size() == 4));
      chk($sformatf("rnd%0d empty", n), 32'(Empty), 32'(mq.size() == 0));
`ifdef DF_MID_LSDC_AGEPICK14_CHK_EN
      chk($sformatf("rnd%0d errchk", n), 32'(ErrChk), 32'(merr));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
